// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mul_share_arbiter
// Brief    : Round-robin share of one signed 32x32 multiplier among NUM_REQ
//            requesters, with a stallable MUL_LATENCY-stage result pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module mul_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 2,
    parameter int ID_W        = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ID_W-1:0]         res_id,
    output logic [63:0]             res_product,
    output logic                    busy
);

    localparam int c_PIPE_STAGES = (MUL_LATENCY > 1) ? MUL_LATENCY - 1 : 1;

    logic              w_adv;
    logic              w_found;
    logic [ID_W-1:0]   w_win;
    logic [ID_W:0]     w_idx;
    logic [31:0]       w_sel_a;
    logic [31:0]       w_sel_b;
    logic              w_accept;
    logic [63:0]       w_product;

    logic [ID_W-1:0]   r_rr_ptr;
    logic              r_s1_valid;
    logic [31:0]       r_s1_a;
    logic [31:0]       r_s1_b;
    logic [ID_W-1:0]   r_s1_id;

    assign w_adv = !res_valid | res_ready;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_idx >= (ID_W+1)'(NUM_REQ)) begin
                w_idx = w_idx - (ID_W+1)'(NUM_REQ);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && (w_idx == (ID_W+1)'(i)) && req_valid[i]) begin
                    w_found = 1'b1;
                    w_win   = ID_W'(i);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == ID_W'(i)) begin
                req_ready[i] = w_adv & w_found & !rst;
                w_sel_a      = req_a[32*i +: 32];
                w_sel_b      = req_b[32*i +: 32];
            end
        end
    end

    assign w_accept = |(req_valid & req_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= ID_W'(NUM_REQ - 1);
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_id    <= '0;
        end else begin
            if (w_accept) begin
                r_rr_ptr <= w_win;
            end
            if (w_adv) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_a  <= w_sel_a;
                    r_s1_b  <= w_sel_b;
                    r_s1_id <= w_win;
                end
            end
        end
    end

    // Shared multiplier: full-width signed product of the stage-1 operands.
    assign w_product = $signed({{32{r_s1_a[31]}}, r_s1_a}) *
                       $signed({{32{r_s1_b[31]}}, r_s1_b});

    generate
        if (MUL_LATENCY == 1) begin : g_comb_out
            assign res_valid   = r_s1_valid;
            assign res_id      = r_s1_id;
            assign res_product = w_product;
            assign busy        = r_s1_valid;
        end else begin : g_pipe_out
            logic [c_PIPE_STAGES-1:0] r_pv;
            logic [ID_W-1:0]          r_pid [c_PIPE_STAGES];
            logic [63:0]              r_pp  [c_PIPE_STAGES];

            // Bubbles shift along with real operations so ordering is preserved.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pv <= '0;
                    for (int j = 0; j < c_PIPE_STAGES; j++) begin
                        r_pid[j] <= '0;
                        r_pp[j]  <= '0;
                    end
                end else if (w_adv) begin
                    r_pv[0]  <= r_s1_valid;
                    r_pid[0] <= r_s1_id;
                    r_pp[0]  <= w_product;
                    for (int j = 1; j < c_PIPE_STAGES; j++) begin
                        r_pv[j]  <= r_pv[j-1];
                        r_pid[j] <= r_pid[j-1];
                        r_pp[j]  <= r_pp[j-1];
                    end
                end
            end

            assign res_valid   = r_pv[c_PIPE_STAGES-1];
            assign res_id      = r_pid[c_PIPE_STAGES-1];
            assign res_product = r_pp[c_PIPE_STAGES-1];
            assign busy        = r_s1_valid | (|r_pv);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_share_arbiter
// Brief    : Directed self-checking bench for mul_share_arbiter (4 req, lat 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_share_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic         res_valid;
    logic         res_ready;
    logic [1:0]   res_id;
    logic [63:0]  res_product;
    logic         busy;

    logic [31:0]  a [4];
    logic [31:0]  b [4];

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] exp2 [4];
    logic [31:0] ca   [4];
    logic [31:0] cb   [4];
    logic [63:0] ce   [4];
    logic [3:0]  g5   [4];
    logic [1:0]  id5  [4];
    logic [63:0] p5   [4];

    assign req_a = {a[3], a[2], a[1], a[0]};
    assign req_b = {b[3], b[2], b[1], b[0]};

    mul_share_arbiter #(
        .NUM_REQ     (4),
        .MUL_LATENCY (2),
        .ID_W        (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_id      (res_id),
        .res_product (res_product),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a[i] = '0;
            b[i] = '0;
        end
        exp2[0] = -64'sd5;  exp2[1] = -64'sd12; exp2[2] = -64'sd21; exp2[3] = -64'sd32;
        ca[0] = 32'h8000_0000; cb[0] = 32'h8000_0000; ce[0] = 64'h4000_0000_0000_0000;
        ca[1] = 32'h8000_0000; cb[1] = 32'h7FFF_FFFF; ce[1] = 64'hC000_0000_8000_0000;
        ca[2] = 32'h0000_0000; cb[2] = 32'hFFFF_FFFF; ce[2] = 64'h0;
        ca[3] = 32'hFFFF_FFFF; cb[3] = 32'hFFFF_FFFF; ce[3] = 64'h1;
        g5[0] = 4'b0010; g5[1] = 4'b1000; g5[2] = 4'b0010; g5[3] = 4'b0010;
        id5[0] = 2'd1; id5[1] = 2'd3; id5[2] = 2'd1; id5[3] = 2'd1;
        p5[0] = 64'd12; p5[1] = -64'sd30; p5[2] = 64'd12; p5[3] = 64'd12;

        // Single operation through an idle pipeline
        cyc();
        cyc();
        a[0] = 32'd7;
        b[0] = -32'sd3;
        req_valid = 4'b0001;
        #1;
        chk("ready_in_reset", 64'(req_ready), 64'h0);
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_res_valid", 64'(res_valid), 64'h0);
        chk("rst_res_id", 64'(res_id), 64'h0);
        chk("rst_res_product", res_product, 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("t1_ready", 64'(req_ready), 64'h1);
        res_ready = 1'b1;
        cyc();
        req_valid = '0;
        #1;
        chk("t1_busy", 64'(busy), 64'h1);
        chk("t1_early_valid", 64'(res_valid), 64'h0);
        cyc();
        chk("t1_res_valid", 64'(res_valid), 64'h1);
        chk("t1_res_id", 64'(res_id), 64'h0);
        chk("t1_product", res_product, 64'hFFFF_FFFF_FFFF_FFEB);
        cyc();
        chk("t1_done_valid", 64'(res_valid), 64'h0);
        chk("t1_done_busy", 64'(busy), 64'h0);

        // All requesters valid: round-robin, back-to-back results
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a[i] = 32'(i + 1);
            b[i] = -32'(i + 5);
        end
        req_valid = 4'hF;
        res_ready = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("t2_ready_%0d", c), 64'(req_ready), 64'(1 << (c % 4)));
            if (c >= 2) begin
                chk($sformatf("t2_valid_%0d", c), 64'(res_valid), 64'h1);
                chk($sformatf("t2_id_%0d", c), 64'(res_id), 64'((c - 2) % 4));
                chk($sformatf("t2_prod_%0d", c), res_product, exp2[(c - 2) % 4]);
            end
            cyc();
        end

        // Output stall with a full pipeline
        res_ready = 1'b0;
        #1;
        chk("t3_ready_stall", 64'(req_ready), 64'h0);
        chk("t3_id_stall", 64'(res_id), 64'h2);
        chk("t3_prod_stall", res_product, exp2[2]);
        for (int s = 0; s < 5; s++) begin
            cyc();
            chk($sformatf("t3_ready_%0d", s), 64'(req_ready), 64'h0);
            chk($sformatf("t3_valid_%0d", s), 64'(res_valid), 64'h1);
            chk($sformatf("t3_id_%0d", s), 64'(res_id), 64'h2);
            chk($sformatf("t3_busy_%0d", s), 64'(busy), 64'h1);
        end
        res_ready = 1'b1;
        #1;
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("t3r_ready_%0d", r), 64'(req_ready), 64'(1 << r));
            chk($sformatf("t3r_id_%0d", r), 64'(res_id), 64'((r + 2) % 4));
            chk($sformatf("t3r_prod_%0d", r), res_product, exp2[(r + 2) % 4]);
            cyc();
        end
        req_valid = '0;
        #1;
        chk("t3d_id0", 64'(res_id), 64'h2);
        cyc();
        chk("t3d_id1", 64'(res_id), 64'h3);
        chk("t3d_valid1", 64'(res_valid), 64'h1);
        cyc();
        chk("t3d_valid2", 64'(res_valid), 64'h0);
        chk("t3d_busy2", 64'(busy), 64'h0);

        // Corner operands on requester 0
        req_valid = 4'b0001;
        for (int j = 0; j < 6; j++) begin
            if (j < 4) begin
                a[0] = ca[j];
                b[0] = cb[j];
            end else begin
                req_valid = '0;
            end
            #1;
            if (j < 4) chk($sformatf("t4_ready_%0d", j), 64'(req_ready), 64'h1);
            if (j >= 2) begin
                chk($sformatf("t4_valid_%0d", j), 64'(res_valid), 64'h1);
                chk($sformatf("t4_id_%0d", j), 64'(res_id), 64'h0);
                chk($sformatf("t4_prod_%0d", j), res_product, ce[j - 2]);
            end
            cyc();
        end
        chk("t4_idle_valid", 64'(res_valid), 64'h0);
        chk("t4_idle_busy", 64'(busy), 64'h0);

        // Sparse requesters: 1 and 3, with 3 dropping after one grant
        do_reset();
        a[1] = 32'd3;  b[1] = 32'd4;
        a[3] = -32'sd5; b[3] = 32'd6;
        req_valid = 4'b1010;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) req_valid = 4'b0010;
            #1;
            if (k < 4) chk($sformatf("t5_ready_%0d", k), 64'(req_ready), 64'(g5[k]));
            if (k >= 2) begin
                chk($sformatf("t5_id_%0d", k), 64'(res_id), 64'(id5[k - 2]));
                chk($sformatf("t5_prod_%0d", k), res_product, p5[k - 2]);
            end
            cyc();
        end
        req_valid = '0;
        cyc();
        cyc();
        cyc();
        chk("t5_drain_busy", 64'(busy), 64'h0);

        // Reset with two operations in flight
        do_reset();
        a[0] = 32'd2; b[0] = 32'd2;
        a[2] = 32'd9; b[2] = 32'd9;
        req_valid = 4'b0101;
        #1;
        chk("t6_ready0", 64'(req_ready), 64'h1);
        cyc();
        chk("t6_ready1", 64'(req_ready), 64'h4);
        cyc();
        chk("t6_busy_pre", 64'(busy), 64'h1);
        chk("t6_valid_pre", 64'(res_valid), 64'h1);
        rst = 1'b1;
        #1;
        chk("t6_ready_rst", 64'(req_ready), 64'h0);
        cyc();
        rst = 1'b0;
        req_valid = 4'b0110;
        #1;
        chk("t6_valid_post", 64'(res_valid), 64'h0);
        chk("t6_busy_post", 64'(busy), 64'h0);
        chk("t6_ready_post", 64'(req_ready), 64'h2);
        cyc();
        chk("t6_valid_post2", 64'(res_valid), 64'h0);
        req_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
